// File: rtl/tlb_miss_table.sv
// Shared TLB-miss slot table: cores post, claim and complete page misses through per-port windows.
// Define TLB_MISS_COALESCE_EN to merge submits of an already-tracked PFN into the existing slot.

module tlb_miss_table #(
    parameter int unsigned  NumPorts   = 8,
    parameter int unsigned  NumEntries = 4,
    parameter int unsigned  PfnWidth   = 52,
    localparam int unsigned IdxW       = (NumEntries > 1) ? $clog2(NumEntries) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NumPorts-1:0]       req_i,
    input  logic [NumPorts-1:0][31:0] add_i,
    input  logic [NumPorts-1:0]       wen_i,
    input  logic [NumPorts-1:0][31:0] wdata_i,
    output logic [NumPorts-1:0]       gnt_o,
    output logic [NumPorts-1:0]       rvalid_o,
    output logic [NumPorts-1:0][31:0] rdata_o,
    output logic [IdxW:0]             pending_o
);

    // state     | meaning
    // ST_IDLE   | port accepts any access
    // ST_AWAIT  | submit outstanding, port ignored until its slot is released
    // ST_UPPER  | port holds claimed slot cl_q, next access returns to idle
    typedef enum logic [1:0] {ST_IDLE, ST_AWAIT, ST_UPPER} state_e;

    localparam int unsigned PtrW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    state_e              state_q [NumPorts], state_d [NumPorts];
    logic [19:0]         pfn_lo_q [NumPorts], pfn_lo_d [NumPorts];
    logic [IdxW-1:0]     cl_q [NumPorts], cl_d [NumPorts];
    logic [NumPorts-1:0] rvalid_q, rvalid_d;
    logic [NumPorts-1:0][31:0] rdata_q, rdata_d;

    logic [NumEntries-1:0] occ_q, occ_d, clm_q, clm_d;
    logic [PfnWidth-1:0]   pfn_q [NumEntries], pfn_d [NumEntries];
    logic [NumPorts-1:0]   wait_q [NumEntries], wait_d [NumEntries];
    logic [IdxW-1:0]       fifo_q [NumEntries], fifo_d [NumEntries];
    logic [IdxW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [IdxW:0]         cnt_q, cnt_d;
    logic [PtrW-1:0]       rr_q, rr_d;

    logic [NumPorts-1:0]   sub_req, clm_req, cmp_req, direct, elig, gnt, rel, match, cvalid;
    logic [IdxW-1:0]       match_idx [NumPorts], cidx [NumPorts];
    logic [PfnWidth-1:0]   sub_pfn [NumPorts];
    logic [NumEntries-1:0] cmp_hit;
    logic                  free_any, win_vld;
    logic [IdxW-1:0]       free_idx, pop_idx;
    logic [PtrW-1:0]       win;
    logic [15:0]           occ_cnt;
    logic [31:0]           status;
    logic                  unused_bits;

    assign unused_bits = ^{add_i, wdata_i};

    function automatic logic [IdxW-1:0] ptr_inc(input logic [IdxW-1:0] v);
        return (int'(v) == int'(NumEntries) - 1) ? '0 : v + IdxW'(1);
    endfunction

    always_comb begin
        sub_req = '0; clm_req = '0; cmp_req = '0; direct = '0;
        match = '0; cvalid = '0; cmp_hit = '0; elig = '0;
        for (int p = 0; p < int'(NumPorts); p++) begin
            sub_pfn[p]   = {wdata_i[p][PfnWidth-21:0], pfn_lo_q[p]};
            cidx[p]      = wdata_i[p][IdxW-1:0];
            match_idx[p] = '0;
            if (req_i[p] && state_q[p] == ST_IDLE) begin
                sub_req[p] = !wen_i[p] && add_i[p][7:0] == 8'h04;
                clm_req[p] = wen_i[p] && add_i[p][7:0] == 8'h10;
                cmp_req[p] = !wen_i[p] && add_i[p][7:0] == 8'h20;
                direct[p]  = !(sub_req[p] || clm_req[p] || cmp_req[p]);
            end else if (req_i[p] && state_q[p] == ST_UPPER) begin
                direct[p] = 1'b1;
            end
`ifdef TLB_MISS_COALESCE_EN
            for (int s = int'(NumEntries) - 1; s >= 0; s--) begin
                if (occ_q[s] && pfn_q[s] == sub_pfn[p]) begin
                    match[p]     = 1'b1;
                    match_idx[p] = IdxW'(s);
                end
            end
`endif
            if (int'(cidx[p]) < int'(NumEntries)) begin
                cvalid[p] = occ_q[cidx[p]] && clm_q[cidx[p]];
            end
            if (cmp_req[p] && cvalid[p]) cmp_hit[cidx[p]] = 1'b1;
        end

        free_any = 1'b0;
        free_idx = '0;
        occ_cnt  = '0;
        for (int s = int'(NumEntries) - 1; s >= 0; s--) begin
            if (!occ_q[s]) begin
                free_any = 1'b1;
                free_idx = IdxW'(s);
            end
            occ_cnt = occ_cnt + 16'(occ_q[s]);
        end
        status  = {occ_cnt, 16'(cnt_q)};
        pop_idx = fifo_q[rd_ptr_q];

        // A submit matching a slot whose completion is requested now waits, so it re-allocates afterwards.
        for (int p = 0; p < int'(NumPorts); p++) begin
            elig[p] = clm_req[p] || cmp_req[p] ||
                      (sub_req[p] && (match[p] ? !cmp_hit[match_idx[p]] : free_any));
        end

        win_vld = 1'b0;
        win     = '0;
        for (int i = 0; i < int'(NumPorts); i++) begin
            if (!win_vld && elig[(int'(rr_q) + i) % int'(NumPorts)]) begin
                win_vld = 1'b1;
                win     = PtrW'((int'(rr_q) + i) % int'(NumPorts));
            end
        end
        gnt = direct;
        if (win_vld) gnt[win] = 1'b1;
    end

    always_comb begin
        state_d  = state_q;  pfn_lo_d = pfn_lo_q; cl_d   = cl_q;
        rvalid_d = '0;       rdata_d  = '0;
        occ_d    = occ_q;    clm_d    = clm_q;    pfn_d  = pfn_q;  wait_d = wait_q;
        fifo_d   = fifo_q;   rd_ptr_d = rd_ptr_q; wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;    rr_d     = rr_q;     rel    = '0;

        if (win_vld) begin
            rr_d = PtrW'((int'(win) + 1) % int'(NumPorts));
            if (sub_req[win]) begin
                state_d[win] = ST_AWAIT;
                if (match[win]) begin
                    wait_d[match_idx[win]][win] = 1'b1;
                end else begin
                    occ_d[free_idx]       = 1'b1;
                    clm_d[free_idx]       = 1'b0;
                    pfn_d[free_idx]       = sub_pfn[win];
                    wait_d[free_idx]      = '0;
                    wait_d[free_idx][win] = 1'b1;
                    fifo_d[wr_ptr_q]      = free_idx;
                    wr_ptr_d              = ptr_inc(wr_ptr_q);
                    cnt_d                 = cnt_q + (IdxW+1)'(1);
                end
            end else if (clm_req[win]) begin
                rvalid_d[win] = 1'b1;
                if (cnt_q != '0) begin
                    clm_d[pop_idx] = 1'b1;
                    cl_d[win]      = pop_idx;
                    state_d[win]   = ST_UPPER;
                    rd_ptr_d       = ptr_inc(rd_ptr_q);
                    cnt_d          = cnt_q - (IdxW+1)'(1);
                    rdata_d[win]   = {pfn_q[pop_idx][19:0], 1'b0, 11'(pop_idx)};
                end else begin
                    rdata_d[win] = 32'h0000_0800;
                end
            end else begin
                rvalid_d[win] = 1'b1;
                if (cvalid[win]) begin
                    rel               = wait_q[cidx[win]];
                    occ_d[cidx[win]]  = 1'b0;
                    clm_d[cidx[win]]  = 1'b0;
                    wait_d[cidx[win]] = '0;
                end else begin
                    rdata_d[win] = 32'd1;
                end
            end
        end

        for (int p = 0; p < int'(NumPorts); p++) begin
            if (direct[p]) begin
                rvalid_d[p] = 1'b1;
                rdata_d[p]  = 32'd1;
                if (wen_i[p] && add_i[p][7:0] == 8'h30) begin
                    rdata_d[p] = status;
                end else if (state_q[p] == ST_UPPER) begin
                    state_d[p] = ST_IDLE;
                    if (wen_i[p] && add_i[p][7:0] == 8'h14)
                        rdata_d[p] = 32'(pfn_q[cl_q[p]][PfnWidth-1:20]);
                end else if (!wen_i[p] && add_i[p][7:0] == 8'h00) begin
                    pfn_lo_d[p] = wdata_i[p][31:12];
                    rdata_d[p]  = '0;
                end
            end
            if (rel[p]) begin
                state_d[p]  = ST_IDLE;
                rvalid_d[p] = 1'b1;
                rdata_d[p]  = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int p = 0; p < int'(NumPorts); p++) begin
                state_q[p]  <= ST_IDLE;
                pfn_lo_q[p] <= '0;
                cl_q[p]     <= '0;
            end
            for (int s = 0; s < int'(NumEntries); s++) begin
                pfn_q[s]  <= '0;
                wait_q[s] <= '0;
                fifo_q[s] <= '0;
            end
            rvalid_q <= '0;
            rdata_q  <= '0;
            occ_q    <= '0;
            clm_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            rr_q     <= '0;
        end else begin
            state_q  <= state_d;
            pfn_lo_q <= pfn_lo_d;
            cl_q     <= cl_d;
            pfn_q    <= pfn_d;
            wait_q   <= wait_d;
            fifo_q   <= fifo_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            occ_q    <= occ_d;
            clm_q    <= clm_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
        end
    end

    assign gnt_o     = gnt & {NumPorts{rst_ni}};
    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;
    assign pending_o = cnt_q;

endmodule

// File: tb/tb_tlb_miss_table.sv
// Directed bench for tlb_miss_table (8 ports, 4 entries, 52-bit PFN).
// Coalescing expectations follow TLB_MISS_COALESCE_EN.

module tb_tlb_miss_table;

    localparam int NP = 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NP-1:0]       req = '0;
    logic [NP-1:0]       wen = '0;
    logic [NP-1:0][31:0] add = '0;
    logic [NP-1:0][31:0] wdata = '0;
    logic [NP-1:0]       gnt;
    logic [NP-1:0]       rvalid;
    logic [NP-1:0][31:0] rdata;
    logic [2:0]          pending;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tlb_miss_table dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_i     (req),
        .add_i     (add),
        .wen_i     (wen),
        .wdata_i   (wdata),
        .gnt_o     (gnt),
        .rvalid_o  (rvalid),
        .rdata_o   (rdata),
        .pending_o (pending)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Starts #1 after a rising edge; returns #1 after the edge that follows the grant.
    task automatic xfer(input int p, input logic [7:0] a, input logic rd, input logic [31:0] wd,
                        output logic [31:0] dat, output logic [NP-1:0] rv, output int waits);
        req[p]   = 1'b1;
        add[p]   = {24'h0, a};
        wen[p]   = rd;
        wdata[p] = wd;
        waits    = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (gnt[p]) begin
                waits = i;
                break;
            end
        end
        @(posedge clk);
        #1;
        req[p] = 1'b0;
        rv     = rvalid;
        dat    = rdata[p];
        check("xfer_granted", 32'(waits >= 0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0]   d;
        logic [NP-1:0] rv;
        logic [NP-1:0] g;
        int            w;
        int            got_n;
        int            order [5];
        logic [31:0]   exp_d [5];

        order = '{6, 7, 0, 1, 5};
        exp_d = '{32'h1234_5002, 32'h1234_5003, 32'h0000_0000, 32'h0000_0800, 32'h0000_0800};

        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_rdata0", rdata[0], 32'd0);

        // basic post / claim / complete
        xfer(0, 8'h00, 1'b0, 32'h1234_5000, d, rv, w);
        check("t1_lo_rsp", d, 32'd0);
        check("t1_lo_rv", 32'(rv[0]), 32'd1);
        xfer(0, 8'h04, 1'b0, 32'h0000_00AB, d, rv, w);
        check("t1_sub_norsp", 32'(rv[0]), 32'd0);
        check("t1_pending1", 32'(pending), 32'd1);
        xfer(1, 8'h10, 1'b1, 32'd0, d, rv, w);
        check("t1_claim", d, 32'h1234_5000);
        check("t1_pending0", 32'(pending), 32'd0);
        xfer(1, 8'h14, 1'b1, 32'd0, d, rv, w);
        check("t1_upper", d, 32'h0000_00AB);
        xfer(1, 8'h20, 1'b0, 32'd0, d, rv, w);
        check("t1_cmp_rv", 32'(rv), 32'h03);
        check("t1_cmp_rsp", d, 32'd0);
        check("t1_rel_data", rdata[0], 32'd0);
        @(posedge clk);
        #1;
        check("t1_pulse", 32'(rvalid), 32'd0);

        // identical PFN from two ports
        xfer(2, 8'h00, 1'b0, 32'h1234_5000, d, rv, w);
        xfer(3, 8'h00, 1'b0, 32'h1234_5000, d, rv, w);
        xfer(2, 8'h04, 1'b0, 32'h0000_00AB, d, rv, w);
        xfer(3, 8'h04, 1'b0, 32'h0000_00AB, d, rv, w);
`ifdef TLB_MISS_COALESCE_EN
        check("t2_pending", 32'(pending), 32'd1);
        xfer(4, 8'h30, 1'b1, 32'd0, d, rv, w);
        check("t2_status", d, 32'h0001_0001);
        xfer(4, 8'h10, 1'b1, 32'd0, d, rv, w);
        check("t2_claim", d, 32'h1234_5000);
        xfer(4, 8'h14, 1'b1, 32'd0, d, rv, w);
        check("t2_upper", d, 32'h0000_00AB);
        xfer(4, 8'h20, 1'b0, 32'd0, d, rv, w);
        check("t2_release_both", 32'(rv), 32'h1C);
`else
        check("t2_pending", 32'(pending), 32'd2);
        xfer(4, 8'h30, 1'b1, 32'd0, d, rv, w);
        check("t2_status", d, 32'h0002_0002);
        xfer(4, 8'h10, 1'b1, 32'd0, d, rv, w);
        check("t2_claim0", d, 32'h1234_5000);
        xfer(4, 8'h14, 1'b1, 32'd0, d, rv, w);
        check("t2_upper0", d, 32'h0000_00AB);
        xfer(4, 8'h20, 1'b0, 32'd0, d, rv, w);
        check("t2_release0", 32'(rv), 32'h14);
        xfer(4, 8'h10, 1'b1, 32'd0, d, rv, w);
        check("t2_claim1", d, 32'h1234_5001);
        xfer(4, 8'h14, 1'b1, 32'd0, d, rv, w);
        check("t2_upper1", d, 32'h0000_00AB);
        xfer(4, 8'h20, 1'b0, 32'd1, d, rv, w);
        check("t2_release1", 32'(rv), 32'h18);
`endif
        check("t2_pending_end", 32'(pending), 32'd0);

        // claim with empty FIFO keeps the port idle
        xfer(6, 8'h10, 1'b1, 32'd0, d, rv, w);
        check("t4_empty_claim", d, 32'h0000_0800);
        xfer(6, 8'h00, 1'b0, 32'd0, d, rv, w);
        check("t4_still_idle", d, 32'd0);

        // fill the table, stall a fifth submit
        xfer(0, 8'h04, 1'b0, 32'd1, d, rv, w);
        xfer(1, 8'h04, 1'b0, 32'd2, d, rv, w);
        xfer(2, 8'h04, 1'b0, 32'd3, d, rv, w);
        xfer(3, 8'h04, 1'b0, 32'd4, d, rv, w);
        check("t3_pending4", 32'(pending), 32'd4);
        req[4]   = 1'b1;
        add[4]   = 32'h04;
        wen[4]   = 1'b0;
        wdata[4] = 32'd5;
        xfer(5, 8'h20, 1'b0, 32'd1, d, rv, w);
        check("t3_unclaimed_rsp", d, 32'd1);
        check("t3_unclaimed_rv", 32'(rv), 32'h20);
        check("t3_unclaimed_pend", 32'(pending), 32'd4);
        @(negedge clk);
        check("t3_stall", 32'(gnt[4]), 32'd0);
        @(posedge clk);
        #1;
        xfer(5, 8'h10, 1'b1, 32'd0, d, rv, w);
        check("t3_claim0", d, 32'h1234_5000);
        xfer(5, 8'h14, 1'b1, 32'd0, d, rv, w);
        check("t3_upper0", d, 32'd1);
        xfer(5, 8'h20, 1'b0, 32'd0, d, rv, w);
        check("t3_release0", 32'(rv), 32'h21);
        @(negedge clk);
        check("t3_unstall", 32'(gnt[4]), 32'd1);
        @(posedge clk);
        #1;
        req[4] = 1'b0;
        check("t3_sub_norsp", 32'(rvalid[4]), 32'd0);
        check("t3_pending_refill", 32'(pending), 32'd4);
        xfer(5, 8'h10, 1'b1, 32'd0, d, rv, w);
        check("t3_claim1", d, 32'h0000_0001);
        xfer(5, 8'h14, 1'b1, 32'd0, d, rv, w);
        check("t3_upper1", d, 32'd2);
        xfer(5, 8'h20, 1'b0, 32'd1, d, rv, w);
        check("t3_release1", 32'(rv), 32'h22);
        check("t3_pending3", 32'(pending), 32'd3);

        // every port claims at once; ports 2..4 are awaiting and ignored
        req   = '1;
        wen   = '1;
        for (int p = 0; p < NP; p++) add[p] = 32'h10;
        got_n = 0;
        for (int c = 0; c < 40 && got_n < 5; c++) begin
            @(negedge clk);
            g = gnt;
            check("t5_onehot", 32'($countones(g)), 32'd1);
            @(posedge clk);
            #1;
            for (int p = 0; p < NP; p++) begin
                if (g[p] && got_n < 5) begin
                    req[p] = 1'b0;
                    check("t5_port", 32'(p), 32'(order[got_n]));
                    check("t5_data", rdata[p], exp_d[got_n]);
                    got_n++;
                end
            end
        end
        check("t5_count", 32'(got_n), 32'd5);
        req = '0;
        xfer(1, 8'h30, 1'b1, 32'd0, d, rv, w);
        check("t5_status", d, 32'h0003_0000);

        // reset while ports 2..4 await release
        rst_n  = 1'b0;
        req[5] = 1'b1;
        add[5] = 32'h30;
        wen[5] = 1'b1;
        #2;
        check("t6_gnt", 32'(gnt), 32'd0);
        check("t6_rvalid", 32'(rvalid), 32'd0);
        check("t6_rdata", 32'(|rdata), 32'd0);
        check("t6_pending", 32'(pending), 32'd0);
        @(posedge clk);
        #1;
        req[5] = 1'b0;
        rst_n  = 1'b1;
        xfer(2, 8'h00, 1'b0, 32'h0000_1000, d, rv, w);
        check("t6_imm_gnt", 32'(w), 32'd0);
        check("t6_lo_rsp", d, 32'd0);
        xfer(5, 8'h30, 1'b1, 32'd0, d, rv, w);
        check("t6_status", d, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
